// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - 4x4 matrix keypad scanner with debounce and hex key output
module keypad_scanner #(
    parameter int SCAN_DIV       = 100000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       mclk,
    input  logic       reset,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] key,
    output logic       key_valid,
    output logic       key_down
);

    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_SCANS);
    // Candidate encoding: bit 4 set means a single valid key, all-zero means NONE.
    localparam logic [4:0] CAND_NONE = 5'b0_0000;

    typedef enum logic [2:0] {
        S_COL0,
        S_COL1,
        S_COL2,
        S_COL3,
        S_EVAL
    } state_t;

    state_t           state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [3:0]       row_meta_q, row_sync_q;
    logic [15:0]      map_q, map_d;
    logic [4:0]       prev_q, prev_d;
    logic [4:0]       acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       key_q, key_d;
    logic             key_valid_q, key_valid_d;
    logic             key_down_q, key_down_d;

    logic [1:0]       col_idx;
    logic             slot_end;
    logic [4:0]       n_pressed;
    logic [3:0]       hit_idx;
    logic [4:0]       cand;
    logic [CNT_W-1:0] cnt_next;

    function automatic logic [3:0] code_of(input logic [3:0] idx);
        // idx = {column, row}
        logic [3:0] code;
        case ({idx[1:0], idx[3:2]})
            4'b00_00: code = 4'h1;
            4'b00_01: code = 4'h2;
            4'b00_10: code = 4'h3;
            4'b00_11: code = 4'hA;
            4'b01_00: code = 4'h4;
            4'b01_01: code = 4'h5;
            4'b01_10: code = 4'h6;
            4'b01_11: code = 4'hB;
            4'b10_00: code = 4'h7;
            4'b10_01: code = 4'h8;
            4'b10_10: code = 4'h9;
            4'b10_11: code = 4'hC;
            4'b11_00: code = 4'h0;
            4'b11_01: code = 4'hF;
            4'b11_10: code = 4'hE;
            default:  code = 4'hD;
        endcase
        return code;
    endfunction

    always_ff @(posedge mclk or posedge reset) begin
        if (reset) begin
            row_meta_q <= 4'b1111;
            row_sync_q <= 4'b1111;
        end else begin
            row_meta_q <= row;
            row_sync_q <= row_meta_q;
        end
    end

    // EVAL is also the first cycle of the column-0 slot, so it drives column 0.
    always_comb begin
        col_idx = 2'd0;
        case (state_q)
            S_COL1:  col_idx = 2'd1;
            S_COL2:  col_idx = 2'd2;
            S_COL3:  col_idx = 2'd3;
            default: col_idx = 2'd0;
        endcase
    end

    always_comb begin
        col = 4'b1110;
        case (col_idx)
            2'd1:    col = 4'b1101;
            2'd2:    col = 4'b1011;
            2'd3:    col = 4'b0111;
            default: col = 4'b1110;
        endcase
    end

    assign slot_end = (div_q == DIV_LAST);

    always_comb begin
        n_pressed = 5'd0;
        hit_idx   = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (map_q[i]) begin
                n_pressed = n_pressed + 5'd1;
                hit_idx   = 4'(i);
            end
        end
        cand = (n_pressed == 5'd1) ? {1'b1, code_of(hit_idx)} : CAND_NONE;
    end

    always_comb begin
        state_d     = state_q;
        div_d       = slot_end ? '0 : div_q + 1'b1;
        map_d       = map_q;
        prev_d      = prev_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        key_d       = key_q;
        key_valid_d = 1'b0;
        key_down_d  = key_down_q;
        cnt_next    = cnt_q;

        if (slot_end) begin
            map_d[{col_idx, 2'b00} +: 4] = ~row_sync_q;
        end

        case (state_q)
            S_COL0:  if (slot_end) state_d = S_COL1;
            S_COL1:  if (slot_end) state_d = S_COL2;
            S_COL2:  if (slot_end) state_d = S_COL3;
            S_COL3:  if (slot_end) state_d = S_EVAL;
            default: state_d = S_COL0;
        endcase

        if (state_q == S_EVAL) begin
            if (cand == prev_q) begin
                cnt_next = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + 1'b1;
            end else begin
                cnt_next = CNT_W'(1);
            end
            cnt_d  = cnt_next;
            prev_d = cand;
            if (cnt_next >= CNT_MAX && cand != acc_q) begin
                acc_d = cand;
                if (cand[4]) begin
                    key_d       = cand[3:0];
                    key_down_d  = 1'b1;
                    key_valid_d = 1'b1;
                end else begin
                    key_down_d  = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge mclk or posedge reset) begin
        if (reset) begin
            state_q     <= S_COL0;
            div_q       <= '0;
            map_q       <= '0;
            prev_q      <= CAND_NONE;
            acc_q       <= CAND_NONE;
            cnt_q       <= '0;
            key_q       <= 4'h0;
            key_valid_q <= 1'b0;
            key_down_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            map_q       <= map_d;
            prev_q      <= prev_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            key_q       <= key_d;
            key_valid_q <= key_valid_d;
            key_down_q  <= key_down_d;
        end
    end

    assign key       = key_q;
    assign key_valid = key_valid_q;
    assign key_down  = key_down_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// tb/tb_keypad_scanner.sv - bench for keypad_scanner with keypad model and pulse scoreboard
module tb_keypad_scanner;

    localparam int SCAN_DIV       = 4;
    localparam int DEBOUNCE_SCANS = 2;
    localparam int SCAN_CYC       = 4 * SCAN_DIV;

    logic       mclk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] row;
    logic [3:0] col;
    logic [3:0] key;
    logic       key_valid;
    logic       key_down;

    logic [15:0] pressed = 16'h0;   // bit c*4+r: key at row r, column c held
    logic [3:0]  sb[$];
    int          checks = 0;
    int          errors = 0;

    typedef struct {
        string       name;
        logic [15:0] mask;
        int          scans;
        logic [3:0]  exp_key;
        logic        exp_down;
        logic        pulse;
        logic        rst_before;
    } vec_t;

    vec_t vecs[$];

    keypad_scanner #(
        .SCAN_DIV      (SCAN_DIV),
        .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
    ) dut (
        .mclk     (mclk),
        .reset    (reset),
        .row      (row),
        .col      (col),
        .key      (key),
        .key_valid(key_valid),
        .key_down (key_down)
    );

    always #5 mclk = ~mclk;

    always_comb begin
        row = 4'b1111;
        for (int c = 0; c < 4; c++) begin
            if (col[c] == 1'b0) begin
                for (int r = 0; r < 4; r++) begin
                    if (pressed[c*4+r]) row[r] = 1'b0;
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add_vec(input string name, input logic [15:0] mask, input int scans,
                           input logic [3:0] exp_key, input logic exp_down,
                           input logic pulse, input logic rst_before);
        vec_t v;
        v.name = name; v.mask = mask; v.scans = scans; v.exp_key = exp_key;
        v.exp_down = exp_down; v.pulse = pulse; v.rst_before = rst_before;
        vecs.push_back(v);
    endtask

    function automatic logic [3:0] col_at(input int cyc);
        logic [3:0] pat [4];
        pat[0] = 4'b1110; pat[1] = 4'b1101; pat[2] = 4'b1011; pat[3] = 4'b0111;
        return pat[(cyc / SCAN_DIV) % 4];
    endfunction

    always @(negedge mclk) begin
        if (!reset && key_valid) begin
            if (sb.size() == 0) begin
                check("unexpected_pulse", {28'h0, key}, 32'hFFFF_FFFF);
            end else begin
                check("pulse_key", {28'h0, key}, {28'h0, sb.pop_front()});
            end
        end
    end

    initial begin
        add_vec("idle",      16'h0000,            2, 4'h0, 1'b0, 1'b0, 1'b0);
        add_vec("hold5",     16'h0020,            5, 4'h5, 1'b1, 1'b1, 1'b0);
        add_vec("rel5_1",    16'h0000,            1, 4'h5, 1'b1, 1'b0, 1'b0);
        add_vec("rel5_2",    16'h0000,            1, 4'h5, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            add_vec("bounce8_on",  16'h0040, 1, 4'h5, 1'b0, 1'b0, 1'b0);
            add_vec("bounce8_off", 16'h0000, 1, 4'h5, 1'b0, 1'b0, 1'b0);
        end
        add_vec("ghost12",   16'h0011,            4, 4'h5, 1'b0, 1'b0, 1'b0);
        add_vec("only1",     16'h0001,            2, 4'h1, 1'b1, 1'b1, 1'b0);
        add_vec("to_D",      16'h8000,            2, 4'hD, 1'b1, 1'b1, 1'b0);
        add_vec("rst_D_1",   16'h8000,            1, 4'h0, 1'b0, 1'b0, 1'b1);
        add_vec("rst_D_2",   16'h8000,            1, 4'hD, 1'b1, 1'b1, 1'b0);

        repeat (3) @(negedge mclk);
        #1;
        check("rst_col", {28'h0, col}, 32'he);
        check("rst_key", {28'h0, key}, 32'h0);
        check("rst_valid", {31'h0, key_valid}, 32'h0);
        check("rst_down", {31'h0, key_down}, 32'h0);
        @(negedge mclk);
        reset = 1'b0;

        for (int c = 0; c <= SCAN_CYC; c++) begin
            if (c > 0) @(negedge mclk);
            #1;
            check($sformatf("idle_col_c%0d", c), {28'h0, col}, {28'h0, col_at(c)});
            check("idle_outs", {26'h0, key, key_valid, key_down}, 32'h0);
        end
        @(negedge mclk);
        #2;

        foreach (vecs[i]) begin
            if (vecs[i].rst_before) begin
                reset = 1'b1;
                #1;
                check("midrst_key", {28'h0, key}, 32'h0);
                check("midrst_down", {31'h0, key_down}, 32'h0);
                check("midrst_valid", {31'h0, key_valid}, 32'h0);
                check("midrst_col", {28'h0, col}, 32'he);
                repeat (2) @(negedge mclk);
                reset = 1'b0;
                @(negedge mclk);
                #2;
            end
            pressed = vecs[i].mask;
            if (vecs[i].pulse) sb.push_back(vecs[i].exp_key);
            repeat (vecs[i].scans * SCAN_CYC) @(posedge mclk);
            @(negedge mclk);
            #2;
            check({vecs[i].name, "_key"}, {28'h0, key}, {28'h0, vecs[i].exp_key});
            check({vecs[i].name, "_down"}, {31'h0, key_down}, {31'h0, vecs[i].exp_down});
            check({vecs[i].name, "_pending"}, sb.size(), 32'h0);
            check({vecs[i].name, "_col"}, {28'h0, col}, 32'he);
        end

        pressed = 16'h0;
        repeat (4 * SCAN_CYC) @(posedge mclk);
        @(negedge mclk);
        check("final_down", {31'h0, key_down}, 32'h0);
        check("final_pending", sb.size(), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Input-side counterpart of the multiplexed seven-segment display path.
- Scans a 4x4 matrix keypad (PmodKYPD layout) by driving one active-low column at a time and sampling the active-low rows.
- Debounces the scan result and presents a 4-bit hex key code with a one-cycle valid strobe and a held-level flag.
- The key code is directly consumable by sseg_driver as its num input.

Parameters:
- SCAN_DIV, 100000, mclk cycles per column slot; minimum 4.
- DEBOUNCE_SCANS, 4, consecutive identical full-scan results needed to accept a change; minimum 1.

Ports:
- mclk  input  1  system clock; all state is in this single clock domain.
- reset  input  1  asynchronous, active-high reset.
- row  input  4  keypad rows, active low, pulled up externally; asynchronous to mclk.
- col  output  4  keypad columns, active low; exactly one bit low at all times.
- key  output  4  hex code of the last accepted key.
- key_valid  output  1  one-cycle pulse when a new key press is accepted.
- key_down  output  1  high while an accepted key is held.

Behaviour:
- Reset values (applied asynchronously, on reset assertion):
  - col=4'b1110, key=4'h0, key_valid=0, key_down=0.
  - Divider=0, column index=0, scan map cleared, debounce count=0.
  - Accepted and previous candidates = NONE.
- Row synchroniser:
  - row passes through a 2-FF synchroniser before use.
  - The flops reset to 4'b1111.
- Column sequencing:
  - A divider counts 0..SCAN_DIV-1; its width is clog2(SCAN_DIV).
  - Column index 0..3 drives col as 1110, 1101, 1011, 0111.
  - On the edge where divider==SCAN_DIV-1:
    - The synchronised row is latched into the scan map for the current column.
    - The column index advances, wrapping 3 to 0.
    - The divider returns to 0.
  - Sampling at the end of the slot gives the rows SCAN_DIV-1 cycles to settle.
- Key map (row r low while column c is driven low):
  - r0: 1 2 3 A
  - r1: 4 5 6 B
  - r2: 7 8 9 C
  - r3: 0 F E D
  - Columns c0..c3 run left to right.
- Scan evaluation:
  - Occurs in the cycle after the column-3 sample edge. Internally this is the EVAL step.
  - The FSM sequence is COL0, COL1, COL2, COL3, EVAL, then back to COL0.
  - EVAL overlaps the first cycle of the next COL0 slot, so scanning never stalls.
  - Candidate = the key code if exactly one of the 16 map bits is pressed.
  - Candidate = NONE if zero keys are pressed, or if two or more are pressed (ghosting protection; multiple keys are never reported).
- Debounce counter:
  - If candidate == previous candidate, the count increments, saturating at DEBOUNCE_SCANS.
  - Otherwise the count is set to 1.
  - The previous candidate is then set to the current candidate.
- Acceptance:
  - Condition: count (after update) >= DEBOUNCE_SCANS and candidate != accepted.
  - Candidate is key K: key<=K, key_down<=1, key_valid high for exactly one cycle. This also covers a direct K to J transition, which pulses again.
  - Candidate is NONE: key_down<=0, key holds its last value, no pulse.
- Output timing:
  - Outputs are registered and update on the edge that ends EVAL.
  - key_valid is otherwise 0.
- Held key:
  - No repeat pulses while the same key is held.
- Reset mid-operation:
  - All state clears immediately.
  - After release, scanning restarts at column 0.
  - A key still held is re-accepted after DEBOUNCE_SCANS scans and generates a pulse.
- Timing and width rules:
  - Worst-case latency from a stable press to key_valid: (DEBOUNCE_SCANS+1) x 4 x SCAN_DIV + 3 cycles.
  - No arithmetic overflow is possible: the divider wraps explicitly and the debounce count saturates.

Test Plan:
(Parameters: SCAN_DIV=4, DEBOUNCE_SCANS=2; one scan = 16 cycles.)
- Reset, then idle with row=1111:
  - col=1110 for cycles 0-3, then 1101 at cycle 4, 1011 at 8, 0111 at 12, and 1110 at 16.
  - key=0, key_valid=0, key_down=0 throughout.
- Hold key 5 (row1 low whenever col1 is low) for 5 scans:
  - Exactly one key_valid pulse, issued after the second complete scan.
  - key=4'h5 and key_down=1.
  - No further pulses while the key stays held.
- Release key 5:
  - key_down falls after 2 clean scans.
  - key stays 5 and no pulse is issued.
- Bounce: key 8 pressed for one scan only, alternating with release:
  - No key_valid pulse and no key_down.
- Ghosting: keys 1 and 2 held together for 4 scans:
  - No accept; key_down=0.
  - Then release key 2: key 1 is accepted with key=4'h1 and one pulse.
- Map and reset checks:
  - Key D (row3 low when col3 low) is accepted as key=4'hD.
  - Asserting reset mid-hold clears key, key_down and key_valid immediately and sets col=1110.
  - After reset is released with D still held, D is re-accepted with one pulse after 2 scans.
